// File: rtl/spi_xfer_sequencer_if.sv
// Host, FIFO and SPI-master signal bundle of the SPI transfer sequencer.
// slave is the sequencer's view, master the driving environment's view.
interface spi_xfer_sequencer_if;
  logic        tx_wr_str;
  logic [15:0] tx_wr_data;
  logic        go_str;
  logic        abort_str;
  logic [7:0]  cs_delay;
  logic [7:0]  gap_delay;
  logic        rx_rd_str;
  logic [15:0] rx_rd_data;
  logic [4:0]  tx_count;
  logic [4:0]  rx_count;
  logic        tx_overflow;
  logic        rx_overflow;
  logic        seq_busy;
  logic        seq_done_str;
  logic        SSF;
  logic [15:0] tx_data;
  logic        tx_start_str;
  logic [15:0] rx_data;
  logic        tx_done_str;
  logic        master_busy;

  modport slave (
    input  tx_wr_str, tx_wr_data, go_str, abort_str,
    input  cs_delay, gap_delay, rx_rd_str,
    input  rx_data, tx_done_str, master_busy,
    output rx_rd_data, tx_count, rx_count,
    output tx_overflow, rx_overflow,
    output seq_busy, seq_done_str, SSF,
    output tx_data, tx_start_str
  );

  modport master (
    output tx_wr_str, tx_wr_data, go_str, abort_str,
    output cs_delay, gap_delay, rx_rd_str,
    output rx_data, tx_done_str, master_busy,
    input  rx_rd_data, tx_count, rx_count,
    input  tx_overflow, rx_overflow,
    input  seq_busy, seq_done_str, SSF,
    input  tx_data, tx_start_str
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Burst sequencer: TX/RX word FIFOs around an external SPI master,
// with chip-select setup/hold, inter-word gaps and abort.
module spi_xfer_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input logic                 clk,
  input logic                 resetf,
  spi_xfer_sequencer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] FULL = 5'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CS_SETUP   = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_GAP        = 3'd4;
  localparam logic [2:0] S_CS_HOLD    = 3'd5;
  localparam logic [2:0] S_ABORT_WAIT = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  logic [2:0]  state;
  logic [7:0]  dly_cnt;
  logic [4:0]  words_left;
  logic        ssf_q;
  logic [15:0] tx_data_q;
  logic        tx_ovf_q;
  logic        rx_ovf_q;

  logic        in_idle;
  logic        dly_zero;
  logic        abort_hit;
  logic        go_hit;
  logic        tx_pop;
  logic        rx_push;

  logic [15:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp;
  logic [AW-1:0] tx_rp;
  logic [4:0]  tx_cnt;
  logic        tx_pop_ok;
  logic        tx_push_ok;

  logic [15:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp;
  logic [AW-1:0] rx_rp;
  logic [4:0]  rx_cnt;
  logic        rx_pop_ok;
  logic        rx_push_ok;

  assign in_idle   = state == S_IDLE;
  assign dly_zero  = dly_cnt == 8'd0;
  assign abort_hit = bus.abort_str && !in_idle;
  assign go_hit    = in_idle && bus.go_str
                   && (tx_cnt != 5'd0);
  // The word is popped on the edge entering START so it is
  // already on tx_data while tx_start_str is high.
  assign tx_pop    = !abort_hit && dly_zero
                   && (state == S_CS_SETUP || state == S_GAP);
  assign rx_push   = !abort_hit && bus.tx_done_str
                   && (state == S_WAIT_DONE);

  assign tx_pop_ok  = tx_pop && (tx_cnt != 5'd0);
  assign tx_push_ok = bus.tx_wr_str
                    && (tx_cnt != FULL || tx_pop_ok);
  assign rx_pop_ok  = bus.rx_rd_str && (rx_cnt != 5'd0);
  assign rx_push_ok = rx_push
                    && (rx_cnt != FULL || rx_pop_ok);

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wp] <= bus.tx_wr_data;
    if (rx_push_ok) rx_mem[rx_wp] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= 5'd0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= 5'd0;
    end else begin
      if (tx_push_ok) tx_wp <= tx_wp + AW'(1);
      if (tx_pop_ok)  tx_rp <= tx_rp + AW'(1);
      if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
      if (rx_pop_ok)  rx_rp <= rx_rp + AW'(1);
      tx_cnt <= tx_cnt + 5'(tx_push_ok)
              - 5'(tx_pop_ok);
      rx_cnt <= rx_cnt + 5'(rx_push_ok)
              - 5'(rx_pop_ok);
    end
  end

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      state      <= S_IDLE;
      dly_cnt    <= 8'd0;
      words_left <= 5'd0;
      ssf_q      <= 1'b1;
      tx_data_q  <= 16'h0;
    end else if (abort_hit) begin
      state <= S_ABORT_WAIT;
      ssf_q <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go_hit) begin
            words_left <= tx_cnt;
            ssf_q      <= 1'b0;
            dly_cnt    <= bus.cs_delay;
            state      <= S_CS_SETUP;
          end
        end
        S_CS_SETUP, S_GAP: begin
          if (dly_zero) begin
            tx_data_q  <= tx_mem[tx_rp];
            words_left <= words_left - 5'd1;
            state      <= S_START;
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end
        S_START: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.tx_done_str) begin
            if (words_left != 5'd0) begin
              dly_cnt <= bus.gap_delay;
              state   <= S_GAP;
            end else begin
              dly_cnt <= bus.cs_delay;
              state   <= S_CS_HOLD;
            end
          end
        end
        S_CS_HOLD: begin
          if (dly_zero) begin
            ssf_q <= 1'b1;
            state <= S_DONE;
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end
        S_ABORT_WAIT: begin
          if (!bus.master_busy) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A go clears the sticky flags, but a drop in that cycle still sets them.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (go_hit) begin
        tx_ovf_q <= 1'b0;
        rx_ovf_q <= 1'b0;
      end
      if (bus.tx_wr_str && !tx_push_ok) tx_ovf_q <= 1'b1;
      if (rx_push && !rx_push_ok)       rx_ovf_q <= 1'b1;
    end
  end

  assign bus.tx_count     = tx_cnt;
  assign bus.rx_count     = rx_cnt;
  assign bus.rx_rd_data   = (rx_cnt == 5'd0) ? 16'h0
                          : rx_mem[rx_rp];
  assign bus.tx_overflow  = tx_ovf_q;
  assign bus.rx_overflow  = rx_ovf_q;
  assign bus.seq_busy     = !in_idle;
  assign bus.seq_done_str = state == S_DONE;
  assign bus.SSF          = ssf_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start_str = state == S_START;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: queue-based burst model checked every
// cycle, plus directed scenarios with literal timing/data expectations.
module tb_spi_xfer_sequencer;
  localparam int D = 8;

  logic clk = 1'b0;
  logic resetf = 1'b0;
  spi_xfer_sequencer_if b();

  spi_xfer_sequencer #(.FIFO_DEPTH(D)) dut (
    .clk(clk),
    .resetf(resetf),
    .bus(b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {
    P_IDLE, P_SETUP, P_START, P_WAIT,
    P_GAP, P_HOLD, P_ABW, P_DONE
  } ph_t;

  ph_t ph = P_IDLE;
  int tmr = 0;
  int words = 0;
  logic m_ssf = 1'b1;
  logic [15:0] m_txd = 16'h0;
  logic m_txo = 1'b0;
  logic m_rxo = 1'b0;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];

  always @(posedge clk or negedge resetf) begin : model
    bit popt;
    bit pushr;
    ph_t nx;
    if (!resetf) begin
      ph = P_IDLE; tmr = 0; words = 0;
      m_ssf = 1'b1; m_txd = 16'h0;
      m_txo = 1'b0; m_rxo = 1'b0;
      txq.delete(); rxq.delete();
    end else begin
      popt = 0; pushr = 0; nx = ph;
      if (b.abort_str && ph != P_IDLE) begin
        nx = P_ABW; m_ssf = 1'b1;
      end else begin
        case (ph)
          P_IDLE:
            if (b.go_str && txq.size() > 0) begin
              words = txq.size();
              m_txo = 1'b0; m_rxo = 1'b0;
              m_ssf = 1'b0;
              tmr = b.cs_delay + 1;
              nx = P_SETUP;
            end
          P_SETUP, P_GAP: begin
            tmr--;
            if (tmr == 0) begin nx = P_START; popt = 1; end
          end
          P_START: nx = P_WAIT;
          P_WAIT:
            if (b.tx_done_str) begin
              pushr = 1;
              if (words > 0) begin
                nx = P_GAP; tmr = b.gap_delay + 1;
              end else begin
                nx = P_HOLD; tmr = b.cs_delay + 1;
              end
            end
          P_HOLD: begin
            tmr--;
            if (tmr == 0) begin nx = P_DONE; m_ssf = 1'b1; end
          end
          P_ABW: if (!b.master_busy) nx = P_DONE;
          default: nx = P_IDLE;
        endcase
      end
      if (popt && txq.size() > 0) begin
        m_txd = txq.pop_front();
        words--;
      end
      if (b.rx_rd_str && rxq.size() > 0) void'(rxq.pop_front());
      if (b.tx_wr_str) begin
        if (txq.size() < D) txq.push_back(b.tx_wr_data);
        else m_txo = 1'b1;
      end
      if (pushr) begin
        if (rxq.size() < D) rxq.push_back(b.rx_data);
        else m_rxo = 1'b1;
      end
      ph = nx;
    end
  end

  // ---------------- compare + event monitor ----------------
  bit mon_clr = 0;
  int cyc = 0;
  int t_fall = -1, t_rise = -1, t_bfall = -1, t_sdone = -1;
  int n_sdone = 0, n_start = 0;
  int st_c[$];
  logic [15:0] st_d[$];
  int dn_c[$];
  logic prev_ssf = 1'b1;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    cyc++;
    if (mon_clr) begin
      t_fall = -1; t_rise = -1; t_bfall = -1; t_sdone = -1;
      n_sdone = 0; n_start = 0;
      st_c.delete(); st_d.delete(); dn_c.delete();
    end
    chk("ssf", b.SSF, m_ssf);
    chk("tx_start_str", b.tx_start_str, ph == P_START);
    chk("seq_done_str", b.seq_done_str, ph == P_DONE);
    chk("seq_busy", b.seq_busy, ph != P_IDLE);
    chk("tx_data", b.tx_data, m_txd);
    chk("tx_count", b.tx_count, txq.size());
    chk("rx_count", b.rx_count, rxq.size());
    chk("rx_rd_data", b.rx_rd_data,
        rxq.size() > 0 ? rxq[0] : 16'h0);
    chk("tx_overflow", b.tx_overflow, m_txo);
    chk("rx_overflow", b.rx_overflow, m_rxo);
    if (prev_ssf && !b.SSF && t_fall < 0) t_fall = cyc;
    if (!prev_ssf && b.SSF) t_rise = cyc;
    if (b.tx_start_str) begin
      n_start++;
      st_c.push_back(cyc);
      st_d.push_back(b.tx_data);
    end
    if (b.tx_done_str) dn_c.push_back(cyc);
    if (prev_busy && !b.master_busy) t_bfall = cyc;
    if (b.seq_done_str) begin n_sdone++; t_sdone = cyc; end
    prev_ssf = b.SSF;
    prev_busy = b.master_busy;
  end

  // ---------------- SPI master stand-in ----------------
  int m_lat = 2;
  int m_tail = 0;

  initial begin : master
    logic [15:0] w;
    int lat, tail;
    b.rx_data = 16'h0;
    b.tx_done_str = 1'b0;
    b.master_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (resetf && b.tx_start_str) begin
        w = b.tx_data; lat = m_lat; tail = m_tail;
        @(posedge clk); #1 b.master_busy = 1'b1;
        repeat (lat) @(posedge clk);
        #1 b.rx_data = ~w; b.tx_done_str = 1'b1;
        @(posedge clk); #1 b.tx_done_str = 1'b0;
        repeat (tail) @(posedge clk);
        #1 b.master_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] d);
    b.tx_wr_str = 1'b1; b.tx_wr_data = d;
    tick();
    b.tx_wr_str = 1'b0;
  endtask

  task automatic go();
    b.go_str = 1'b1; tick(); b.go_str = 1'b0;
  endtask

  task automatic rd(output logic [15:0] d);
    d = b.rx_rd_data;
    b.rx_rd_str = 1'b1; tick(); b.rx_rd_str = 1'b0;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic wait_sdone(input int budget, input string nm);
    bit found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (b.seq_done_str) begin found = 1; break; end
    end
    chk(nm, found, 1'b1);
    tick();
  endtask

  task automatic wait_start(input int budget, input string nm);
    bit found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (b.tx_start_str) begin found = 1; break; end
    end
    chk(nm, found, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] d;
    b.tx_wr_str = 0; b.tx_wr_data = 0; b.go_str = 0;
    b.abort_str = 0; b.cs_delay = 0; b.gap_delay = 0;
    b.rx_rd_str = 0;
    repeat (3) tick();
    chk("rst_ssf", b.SSF, 1'b1);
    chk("rst_busy", b.seq_busy, 1'b0);
    chk("rst_start", b.tx_start_str, 1'b0);
    chk("rst_done", b.seq_done_str, 1'b0);
    chk("rst_tx_data", b.tx_data, 16'h0);
    chk("rst_counts", {b.tx_count, b.rx_count}, 10'h0);
    chk("rst_rx_rd_data", b.rx_rd_data, 16'h0);
    chk("rst_ovf", {b.tx_overflow, b.rx_overflow}, 2'b00);
    resetf = 1'b1;
    tick();

    // go with an empty TX FIFO
    clr_mon(); go(); repeat (4) tick();
    chk("empty_go_busy", b.seq_busy, 1'b0);
    chk("empty_go_ssf", b.SSF, 1'b1);
    chk("empty_go_starts", n_start, 0);

    // two-word burst with echoing master
    b.cs_delay = 8'd2; b.gap_delay = 8'd1;
    clr_mon(); wr(16'h1234); wr(16'hABCD); go();
    wait_sdone(80, "burst2_timeout");
    chk("burst2_nstart", st_c.size(), 2);
    chk("burst2_ndone", dn_c.size(), 2);
    if (st_c.size() == 2 && dn_c.size() == 2) begin
      chk("burst2_setup", st_c[0] - t_fall, 3);
      chk("burst2_word0", st_d[0], 16'h1234);
      chk("burst2_word1", st_d[1], 16'hABCD);
      chk("burst2_gap", st_c[1] - dn_c[0] - 1, 2);
      chk("burst2_hold", t_rise - dn_c[1] - 1, 3);
    end
    chk("burst2_seqdone", n_sdone, 1);
    rd(d); chk("burst2_rx0", d, 16'hEDCB);
    rd(d); chk("burst2_rx1", d, 16'h5432);
    chk("burst2_rx_empty", b.rx_count, 0);

    // abort during WAIT_DONE of word 2 of 4
    b.cs_delay = 8'd1; b.gap_delay = 8'd0;
    clr_mon();
    wr(16'h1111); wr(16'h2222); wr(16'h3333); wr(16'h4444);
    go();
    wait_start(40, "abort_start1_timeout");
    tick();
    m_lat = 5; m_tail = 6;
    wait_start(40, "abort_start2_timeout");
    tick(); tick();
    b.abort_str = 1'b1; tick(); b.abort_str = 1'b0;
    chk("abort_ssf_next", b.SSF, 1'b1);
    chk("abort_busy", b.seq_busy, 1'b1);
    wait_sdone(60, "abort_timeout");
    m_lat = 2; m_tail = 0;
    chk("abort_done_lag", t_sdone - t_bfall, 1);
    chk("abort_rx_count", b.rx_count, 1);
    chk("abort_tx_count", b.tx_count, 2);
    chk("abort_nstart", n_start, 2);
    rd(d); chk("abort_rx0", d, 16'hEEEE);

    // reset asserted while in GAP
    b.cs_delay = 8'd0; b.gap_delay = 8'd5;
    wr(16'h5555);
    clr_mon(); go();
    wait_start(40, "rst_start_timeout");
    repeat (5) tick();
    #2 resetf = 1'b0;
    #1;
    chk("midrst_ssf", b.SSF, 1'b1);
    chk("midrst_counts", {b.tx_count, b.rx_count}, 10'h0);
    chk("midrst_busy", b.seq_busy, 1'b0);
    chk("midrst_rx_rd_data", b.rx_rd_data, 16'h0);
    tick(); tick();
    resetf = 1'b1;
    clr_mon(); repeat (12) tick();
    chk("midrst_no_start", n_start, 0);
    chk("midrst_ssf_after", b.SSF, 1'b1);

    // TX overflow: 9 writes into 8 slots, go clears the flag
    b.gap_delay = 8'd0;
    for (int i = 0; i < 9; i++) wr(16'h0100 + 16'(i));
    chk("txovf_count", b.tx_count, 8);
    chk("txovf_flag", b.tx_overflow, 1'b1);
    go();
    chk("txovf_cleared", b.tx_overflow, 1'b0);
    wait_sdone(200, "txovf_burst_timeout");
    chk("txovf_rx_full", b.rx_count, 8);
    chk("txovf_tx_empty", b.tx_count, 0);

    // RX full, read strobe coincides with the last word completing
    wr(16'h0F0F);
    clr_mon(); go();
    wait_start(40, "rxfull_start_timeout");
    repeat (3) tick();
    b.rx_rd_str = 1'b1; tick(); b.rx_rd_str = 1'b0;
    wait_sdone(40, "rxfull_timeout");
    chk("rxfull_count", b.rx_count, 8);
    chk("rxfull_ovf", b.rx_overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd(d);
      if (i == 0) chk("rxfull_first", d, 16'hFEFE);
      if (i == 7) chk("rxfull_last", d, 16'hF0F0);
    end
    rd(d);
    chk("rx_empty_pop_count", b.rx_count, 0);
    chk("rx_empty_pop_data", d, 16'h0);

    // RX overflow: a ninth push with no read drops the word
    for (int i = 0; i < 8; i++) wr(16'h2000 + 16'(i));
    go(); wait_sdone(200, "rxovf_fill_timeout");
    wr(16'h3000);
    go(); wait_sdone(40, "rxovf_timeout");
    chk("rxovf_flag", b.rx_overflow, 1'b1);
    chk("rxovf_count", b.rx_count, 8);
    chk("rxovf_head", b.rx_rd_data, 16'hDFFF);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of 16-bit entries in each of the TX and RX FIFOs (power of 2, 2..16).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 resetf  input  1  asynchronous, active-low reset.
REQ-004 tx_wr_str  input  1  one-cycle strobe; push tx_wr_data into the TX FIFO.
REQ-005 tx_wr_data  input  16  word to transmit.
REQ-006 go_str  input  1  one-cycle strobe; start a burst.
REQ-007 abort_str  input  1  one-cycle strobe; terminate the burst.
REQ-008 cs_delay  input  8  chip-select setup/hold length, in cycles minus one.
REQ-009 gap_delay  input  8  inter-word gap length, in cycles minus one.
REQ-010 rx_rd_str  input  1  one-cycle strobe; pop the RX FIFO head.
REQ-011 rx_rd_data  output  16  RX FIFO head word (first-word fall-through); 0 when empty.
REQ-012 tx_count, rx_count  output  5 each  FIFO occupancy.
REQ-013 tx_overflow, rx_overflow  output  1 each  sticky error flags.
REQ-014 seq_busy  output  1  high whenever the state is not IDLE.
REQ-015 seq_done_str  output  1  one-cycle pulse at burst end, normal or aborted.
REQ-016 SSF  output  1  active-low slave select.
REQ-017 tx_data  output  16  word to the SPI master.
REQ-018 tx_start_str  output  1  one-cycle start pulse to the SPI master.
REQ-019 rx_data  input  16  received word from the SPI master.
REQ-020 tx_done_str  input  1  word-complete pulse from the SPI master.
REQ-021 master_busy  input  1  SPI master activity flag.

Function
REQ-022 States SHALL be IDLE, CS_SETUP, START, WAIT_DONE, GAP, CS_HOLD, ABORT_WAIT and DONE.
REQ-023 IDLE: go_str with tx_count>0 SHALL latch words_left=tx_count, clear both overflow flags, drive SSF low, load the delay counter with cs_delay and enter CS_SETUP; go_str with tx_count=0 SHALL be ignored.
REQ-024 CS_SETUP, GAP and CS_HOLD SHALL decrement the delay counter each cycle and exit when it equals 0, so each lasts delay+1 cycles; a delay of 0 gives 1 cycle.
REQ-025 START SHALL pop the TX FIFO into the tx_data register, pulse tx_start_str for exactly 1 cycle, decrement words_left and enter WAIT_DONE.
REQ-026 tx_data SHALL hold its value until the next START.
REQ-027 WAIT_DONE: on tx_done_str the block SHALL push rx_data into the RX FIFO, then enter GAP (loaded with gap_delay) if words_left>0, otherwise CS_HOLD (loaded with cs_delay).
REQ-028 GAP SHALL exit to START; CS_HOLD SHALL exit to DONE with SSF high from the DONE cycle onward.
REQ-029 DONE SHALL last 1 cycle, pulse seq_done_str and return to IDLE.
REQ-030 abort_str in any non-IDLE state SHALL take priority over every other transition: SSF goes high on the next cycle and the block enters ABORT_WAIT.
REQ-031 ABORT_WAIT SHALL issue no tx_start_str, SHALL ignore tx_done_str (no RX push) and SHALL enter DONE once master_busy=0.
REQ-032 Unsent TX words SHALL remain in the TX FIFO after an abort.
REQ-033 A TX write when tx_count=FIFO_DEPTH SHALL be dropped and SHALL set tx_overflow.
REQ-034 An RX push when rx_count=FIFO_DEPTH SHALL be dropped and SHALL set rx_overflow.
REQ-035 A pop of an empty FIFO SHALL be ignored.
REQ-036 TX writes SHALL be accepted in any state; words written after go_str SHALL be sent only by a later burst.
REQ-037 A simultaneous push and pop on the same FIFO SHALL both take effect, leaving the count unchanged; when full, the pop frees the slot so the push is accepted.
REQ-038 Both FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-039 go_str outside IDLE SHALL be ignored.

Reset
REQ-040 While resetf=0 the block SHALL hold: state IDLE, SSF=1, tx_start_str=0, seq_done_str=0, seq_busy=0, tx_data=0, both FIFOs empty (counts 0, rx_rd_data=0), both overflow flags 0, delay counter 0, words_left 0.
REQ-041 Reset asserted mid-burst SHALL force SSF high immediately and discard all FIFO contents.

Verification
REQ-042 Scenario: write 0x1234 and 0xABCD, cs_delay=2, gap_delay=1, go_str; master model echoes ~tx_data -> SSF low for 3 cycles before the first tx_start_str, tx_data sequence 0x1234 then 0xABCD, 2-cycle gap, 3-cycle hold, RX reads 0xEDCB then 0x5432, one seq_done_str.
REQ-043 Scenario: write 9 words with FIFO_DEPTH=8 -> tx_count=8 and tx_overflow=1; go_str then clears tx_overflow.
REQ-044 Scenario: abort_str during WAIT_DONE of word 2 of 4, master_busy held for 10 more cycles -> SSF high on the next cycle, seq_done_str 1 cycle after master_busy falls, no RX push for word 2, tx_count=2.
REQ-045 Scenario: go_str with an empty TX FIFO -> state stays IDLE, SSF stays 1, no tx_start_str.
REQ-046 Scenario: RX FIFO full while the last word completes, with rx_rd_str asserted in the same cycle -> word accepted, rx_count stays 8, rx_overflow=0.
REQ-047 Scenario: resetf low during GAP -> SSF=1 and all counts 0 immediately; no tx_start_str after resetf is released.
